adc_audio_decimator: RTL and testbench

- Sits between the MCP3202 SPI ADC core and the audio low-pass filter / HDMI audio sample path, in the `clk_135_w` domain.
- Converts 12-bit offset-binary ADC words to two's complement and block-averages 2^DECIM_LOG2 samples.
- Applies a saturating gain and emits a 16-bit signed sample with a one-cycle valid strobe and a clip indication.

---
 rtl/adc_audio_decimator_pkg.sv | 17 +
 rtl/adc_audio_decimator_sat_shift16.sv | 41 ++++
 rtl/adc_audio_decimator.sv | 134 +++++++++++++
 tb/tb_adc_audio_decimator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_audio_decimator_pkg.sv
// Shared constants, sample type and the ADC code conversion for the audio decimator.
package audio_constants;

  localparam int unsigned ADC_WIDTH    = 12;
  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned DC_SHIFT     = 10;

  typedef logic signed [SAMPLE_WIDTH-1:0] audio_sample_t;

  // Offset-binary ADC code (0x800 = midscale) to two's complement.
  function automatic logic signed [ADC_WIDTH-1:0] offset_to_signed(
    input logic [ADC_WIDTH-1:0] code
  );
    return {~code[ADC_WIDTH-1], code[ADC_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/adc_audio_decimator_sat_shift16.sv
// Combinational signed arithmetic shift (left for SHIFT>0, right for SHIFT<0)
// followed by saturation to a 16-bit signed sample, with a clip flag.
module sat_shift16
  import audio_constants::*;
#(
  parameter int unsigned IN_W  = 14,
  parameter int          SHIFT = 2
) (
  input  logic signed [IN_W-1:0] din,
  output audio_sample_t          sample_c,
  output logic                   clip_c
);

  localparam int unsigned LSH  = (SHIFT > 0) ? unsigned'(SHIFT)  : 0;
  localparam int unsigned RSH  = (SHIFT < 0) ? unsigned'(-SHIFT) : 0;
  localparam int unsigned EXT  = IN_W + LSH;
  // At least one bit wider than the sample so the limit compare is meaningful.
  localparam int unsigned WIDE = (EXT > SAMPLE_WIDTH + 1) ? EXT : SAMPLE_WIDTH + 1;

  localparam logic signed [WIDE-1:0] MAX_V = WIDE'(32767);
  localparam logic signed [WIDE-1:0] MIN_V = ~MAX_V;

  logic signed [WIDE-1:0] ext_c;
  logic signed [WIDE-1:0] shifted_c;

  // Full-width shift, then clamp to the 16-bit signed range.
  always_comb begin
    ext_c     = WIDE'(din);
    shifted_c = (ext_c <<< LSH) >>> RSH;
    sample_c  = SAMPLE_WIDTH'(shifted_c);
    clip_c    = 1'b0;
    if (shifted_c > MAX_V) begin
      sample_c = 16'sh7FFF;
      clip_c   = 1'b1;
    end else if (shifted_c < MIN_V) begin
      sample_c = 16'sh8000;
      clip_c   = 1'b1;
    end
  end

endmodule

// File: rtl/adc_audio_decimator.sv
// ADC audio decimator: offset-binary to signed, block average of 2^DECIM_LOG2
// samples, saturating gain, 16-bit output strobe with clip flag.
// Optional build macro ADC_AUDIO_DC_BLOCK_EN adds a one-pole DC remover.
module adc_audio_decimator
  import audio_constants::*;
#(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned GAIN_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output audio_sample_t        sample_out,
  output logic                 sample_valid,
  output logic                 clip
);

  localparam int unsigned CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned ACC_W = ADC_WIDTH + DECIM_LOG2;
  localparam int          SHIFT = 4 - int'(DECIM_LOG2) + int'(GAIN_SHIFT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << DECIM_LOG2) - 1);

  logic signed [ADC_WIDTH-1:0] s_c;
  logic signed [ACC_W-1:0]     sum_next_c;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     sum_r;
  logic [CNT_W-1:0]            count;
  logic                        sum_v;

  audio_sample_t x_sat_c;
  logic          x_clip_c;
  audio_sample_t out_c;
  logic          out_clip_c;

  assign s_c        = offset_to_signed(adc_data);
  assign sum_next_c = acc + ACC_W'(s_c);

  // Stage 1: accumulate one block, hand the sum to stage 2 with a one-cycle flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      count <= '0;
      sum_r <= '0;
      sum_v <= 1'b0;
    end else begin
      sum_v <= 1'b0;
      if (!enable) begin
        acc   <= '0;
        count <= '0;
      end else if (adc_valid) begin
        if (count == LAST) begin
          sum_r <= sum_next_c;
          sum_v <= 1'b1;
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= sum_next_c;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  sat_shift16 #(
    .IN_W  (ACC_W),
    .SHIFT (SHIFT)
  ) u_scale (
    .din      (sum_r),
    .sample_c (x_sat_c),
    .clip_c   (x_clip_c)
  );

`ifdef ADC_AUDIO_DC_BLOCK_EN
  localparam int unsigned DC_W   = SAMPLE_WIDTH + DC_SHIFT;
  localparam int unsigned DIFF_W = SAMPLE_WIDTH + 1;

  logic signed [DC_W-1:0]   dc_acc;
  audio_sample_t            dc_c;
  logic signed [DIFF_W-1:0] diff_c;
  audio_sample_t            y_c;
  logic                     dc_clip_c;

  assign dc_c   = SAMPLE_WIDTH'(dc_acc >>> DC_SHIFT);
  assign diff_c = DIFF_W'(x_sat_c) - DIFF_W'(dc_c);

  sat_shift16 #(
    .IN_W  (DIFF_W),
    .SHIFT (0)
  ) u_dc_sat (
    .din      (diff_c),
    .sample_c (y_c),
    .clip_c   (dc_clip_c)
  );

  // DC estimate integrates the unsaturated residual once per output sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_acc <= '0;
    end else if (!enable) begin
      dc_acc <= '0;
    end else if (sum_v) begin
      dc_acc <= dc_acc + DC_W'(diff_c);
    end
  end

  assign out_c      = y_c;
  assign out_clip_c = x_clip_c | dc_clip_c;
`else
  assign out_c      = x_sat_c;
  assign out_clip_c = x_clip_c;
`endif

  // Stage 2: register the scaled sample; mute and suppress strobes while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else if (!enable) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else begin
      sample_valid <= sum_v;
      clip         <= sum_v & out_clip_c;
      if (sum_v) begin
        sample_out <= out_c;
      end
    end
  end

endmodule

// File: tb/tb_adc_audio_decimator.sv
// Directed bench for adc_audio_decimator. Four instances share the input stimulus:
// 0: DECIM_LOG2=2 GAIN_SHIFT=0, 1: DECIM_LOG2=2 GAIN_SHIFT=1,
// 2: DECIM_LOG2=0 GAIN_SHIFT=0, 3: DECIM_LOG2=6 GAIN_SHIFT=0.
module tb_adc_audio_decimator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        adc_valid;
  logic [11:0] adc_data;

  logic [15:0] so [4];
  logic        sv [4];
  logic        cl [4];

  int          cyc = 0;
  int          last_cyc;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cnt [4];
  int          clipcnt [4];
  logic [15:0] val [4];
  int          scyc [16];
  logic [15:0] sval [16];
  logic [15:0] prev0;
  int          nonmono;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_audio_decimator #(.DECIM_LOG2(2), .GAIN_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_data(adc_data),
    .adc_valid(adc_valid), .sample_out(so[0]), .sample_valid(sv[0]), .clip(cl[0]));
  adc_audio_decimator #(.DECIM_LOG2(2), .GAIN_SHIFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_data(adc_data),
    .adc_valid(adc_valid), .sample_out(so[1]), .sample_valid(sv[1]), .clip(cl[1]));
  adc_audio_decimator #(.DECIM_LOG2(0), .GAIN_SHIFT(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_data(adc_data),
    .adc_valid(adc_valid), .sample_out(so[2]), .sample_valid(sv[2]), .clip(cl[2]));
  adc_audio_decimator #(.DECIM_LOG2(6), .GAIN_SHIFT(0)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_data(adc_data),
    .adc_valid(adc_valid), .sample_out(so[3]), .sample_valid(sv[3]), .clip(cl[3]));

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cl[i] === 1'b1) clipcnt[i]++;
      if (sv[i] === 1'b1) begin
        if (i == 0) begin
          if (cnt[0] < 16) begin
            scyc[cnt[0]] = cyc;
            sval[cnt[0]] = so[0];
          end
          if (cnt[0] > 0 && $signed(so[0]) > $signed(prev0)) nonmono++;
          prev0 = so[0];
        end
        cnt[i]++;
        val[i] = so[i];
      end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      clipcnt[i] = 0;
    end
    nonmono = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      adc_valid = 1'b0;
    end
    #1;
  endtask

  task automatic send(input logic [11:0] d, input int n);
    repeat (n) begin
      @(negedge clk);
      adc_data  = d;
      adc_valid = 1'b1;
      last_cyc  = cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    enable    = 1'b1;
    adc_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    adc_valid = 1'b0;
    adc_data  = 12'h000;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (so[0] !== 16'h0000) $display("FAIL reset_out0: got %h want 0000", so[0]); else pass_cnt++;
    total_cnt++; if (sv[0] !== 1'b0) $display("FAIL reset_valid0: got %b want 0", sv[0]); else pass_cnt++;
    total_cnt++; if (cl[0] !== 1'b0) $display("FAIL reset_clip0: got %b want 0", cl[0]); else pass_cnt++;
    total_cnt++; if (so[1] !== 16'h0000) $display("FAIL reset_out1: got %h want 0000", so[1]); else pass_cnt++;
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_midscale();
    clear_mon();
    send(12'h800, 4);
    idle(6);
    total_cnt++; if (cnt[0] != 1) $display("FAIL mid_count: got %0d want 1", cnt[0]); else pass_cnt++;
    total_cnt++; if (val[0] !== 16'h0000) $display("FAIL mid_value: got %h want 0000", val[0]); else pass_cnt++;
    total_cnt++; if (clipcnt[0] != 0) $display("FAIL mid_clip: got %0d want 0", clipcnt[0]); else pass_cnt++;
    total_cnt++; if (scyc[0] != last_cyc + 2) $display("FAIL mid_latency: got cycle %0d want %0d", scyc[0], last_cyc + 2); else pass_cnt++;
  endtask

  task automatic test_gain();
    clear_mon();
    send(12'hFFF, 4);
    idle(6);
    total_cnt++; if (val[0] !== 16'h7FF0) $display("FAIL fff_g0: got %h want 7ff0", val[0]); else pass_cnt++;
    total_cnt++; if (clipcnt[0] != 0) $display("FAIL fff_g0_clip: got %0d want 0", clipcnt[0]); else pass_cnt++;
    total_cnt++; if (val[1] !== 16'h7FFF) $display("FAIL fff_g1: got %h want 7fff", val[1]); else pass_cnt++;
    total_cnt++; if (clipcnt[1] != 1 || cnt[1] != 1) $display("FAIL fff_g1_clip: got clips %0d strobes %0d want 1 1", clipcnt[1], cnt[1]); else pass_cnt++;
    total_cnt++; if (val[2] !== 16'h7FF0 || cnt[2] != 4) $display("FAIL fff_n1: got %h x%0d want 7ff0 x4", val[2], cnt[2]); else pass_cnt++;
    clear_mon();
    send(12'h000, 4);
    idle(6);
    total_cnt++; if (val[0] !== 16'h8000) $display("FAIL zero_g0: got %h want 8000", val[0]); else pass_cnt++;
    total_cnt++; if (clipcnt[0] != 0) $display("FAIL zero_g0_clip: got %0d want 0", clipcnt[0]); else pass_cnt++;
    total_cnt++; if (val[1] !== 16'h8000 || clipcnt[1] != 1) $display("FAIL zero_g1: got %h clips %0d want 8000 1", val[1], clipcnt[1]); else pass_cnt++;
    total_cnt++; if (val[2] !== 16'h8000 || clipcnt[2] != 0) $display("FAIL zero_n1: got %h clips %0d want 8000 0", val[2], clipcnt[2]); else pass_cnt++;
    clear_mon();
    send(12'hC00, 4);
    idle(6);
    total_cnt++; if (val[0] !== 16'h4000 || clipcnt[0] != 0) $display("FAIL c00_g0: got %h clips %0d want 4000 0", val[0], clipcnt[0]); else pass_cnt++;
    total_cnt++; if (val[1] !== 16'h7FFF || clipcnt[1] != 1) $display("FAIL c00_g1: got %h clips %0d want 7fff 1", val[1], clipcnt[1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send(12'hA00, 16);
    idle(6);
    total_cnt++; if (cnt[0] != 4) $display("FAIL b2b_count: got %0d want 4", cnt[0]); else pass_cnt++;
    total_cnt++; if (cnt[2] != 16) $display("FAIL b2b_n1_count: got %0d want 16", cnt[2]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (sval[i] !== 16'h2000) $display("FAIL b2b_value%0d: got %h want 2000", i, sval[i]); else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (scyc[i+1] - scyc[i] != 4) $display("FAIL b2b_spacing%0d: got %0d want 4", i, scyc[i+1] - scyc[i]); else pass_cnt++;
    end
  endtask

  task automatic test_right_shift();
    do_reset();
    clear_mon();
    send(12'hFFF, 64);
    idle(6);
    total_cnt++; if (cnt[3] != 1 || val[3] !== 16'h7FF0) $display("FAIL d6_fff: got %h x%0d want 7ff0 x1", val[3], cnt[3]); else pass_cnt++;
    send(12'h000, 64);
    idle(6);
    total_cnt++; if (cnt[3] != 2 || val[3] !== 16'h8000) $display("FAIL d6_zero: got %h x%0d want 8000 x2", val[3], cnt[3]); else pass_cnt++;
    total_cnt++; if (clipcnt[3] != 0) $display("FAIL d6_clip: got %0d want 0", clipcnt[3]); else pass_cnt++;
  endtask

  task automatic test_reset_midblock();
    do_reset();
    send(12'hFFF, 2);
    @(negedge clk);
    adc_valid = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    send(12'h900, 4);
    idle(6);
    total_cnt++; if (cnt[0] != 1 || val[0] !== 16'h1000) $display("FAIL rst_mid: got %h x%0d want 1000 x1", val[0], cnt[0]); else pass_cnt++;
    total_cnt++; if (scyc[0] != last_cyc + 2) $display("FAIL rst_mid_latency: got cycle %0d want %0d", scyc[0], last_cyc + 2); else pass_cnt++;
  endtask

  task automatic test_enable_midblock();
    clear_mon();
    send(12'hFFF, 2);
    @(negedge clk);
    adc_valid = 1'b0;
    enable    = 1'b0;
    idle(2);
    total_cnt++; if (so[0] !== 16'h0000) $display("FAIL dis_mute: got %h want 0000", so[0]); else pass_cnt++;
    send(12'hFFF, 5);
    idle(4);
    total_cnt++; if (cnt[0] != 0 || clipcnt[1] != 0) $display("FAIL dis_ignore: got strobes %0d clips %0d want 0 0", cnt[0], clipcnt[1]); else pass_cnt++;
    total_cnt++; if (so[1] !== 16'h0000) $display("FAIL dis_mute1: got %h want 0000", so[1]); else pass_cnt++;
    enable = 1'b1;
    send(12'h900, 4);
    idle(6);
    total_cnt++; if (cnt[0] != 1 || val[0] !== 16'h1000) $display("FAIL en_fresh: got %h x%0d want 1000 x1", val[0], cnt[0]); else pass_cnt++;
  endtask

  task automatic test_enable_fall_last();
    clear_mon();
    send(12'hC00, 3);
    @(negedge clk);
    adc_data  = 12'hC00;
    adc_valid = 1'b1;
    enable    = 1'b0;
    @(negedge clk);
    adc_valid = 1'b0;
    enable    = 1'b1;
    idle(4);
    total_cnt++; if (cnt[0] != 0) $display("FAIL fall_last_drop: got %0d strobes want 0", cnt[0]); else pass_cnt++;
    send(12'hC00, 4);
    idle(6);
    total_cnt++; if (cnt[0] != 1 || val[0] !== 16'h4000) $display("FAIL fall_last_fresh: got %h x%0d want 4000 x1", val[0], cnt[0]); else pass_cnt++;
  endtask

`ifdef ADC_AUDIO_DC_BLOCK_EN
  task automatic test_dc_block();
    do_reset();
    clear_mon();
    send(12'h900, 16384);
    idle(6);
    total_cnt++; if (cnt[0] != 4096) $display("FAIL dc_count: got %0d want 4096", cnt[0]); else pass_cnt++;
    total_cnt++; if (sval[0] !== 16'h1000) $display("FAIL dc_first: got %h want 1000", sval[0]); else pass_cnt++;
    total_cnt++; if (nonmono != 0) $display("FAIL dc_monotonic: got %0d rises want 0", nonmono); else pass_cnt++;
    total_cnt++; if (clipcnt[0] != 0) $display("FAIL dc_clip: got %0d want 0", clipcnt[0]); else pass_cnt++;
    total_cnt++; if ($signed(val[0]) >= 256 || $signed(val[0]) <= -256) $display("FAIL dc_final: got %h want |x| < 0100", val[0]); else pass_cnt++;
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
`ifdef ADC_AUDIO_DC_BLOCK_EN
    test_dc_block();
`else
    test_midscale();
    test_gain();
    test_back_to_back();
    test_right_shift();
    test_reset_midblock();
    test_enable_midblock();
    test_enable_fall_last();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
